// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the ALU arbiter state encoding.
// Imported by the ALU sharing arbiter and any requester that builds ALU opcodes.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  // Highest legal opcode; anything above it is reported as an error.
  localparam logic [3:0] ALU_OP_MAX = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, on a tie the port that did
// not win last time is granted. last_grant only moves when update_i is set.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one integer ALU between the execute stage (port 0) and the address/branch
// helper (port 1). One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,

  output logic [WIDTH-1:0] alu_reg1,
  output logic [WIDTH-1:0] alu_reg2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [OPW-1:0] LegalMax = OPW'(ALU_OP_MAX);

  alu_arb_state_e state_q, state_d;

  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             owner_q;
  logic             err_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             rerr_q;

  logic [1:0]       arb_req;
  logic [1:0]       gnt;
  logic             accept;
  logic             rsp_take;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Requests are only visible to the arbiter in IDLE, so grant implies handshake.
  assign arb_req = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign accept  = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (arb_req),
    .update_i (accept),
    .gnt_o    (gnt)
  );

  assign sel_op   = gnt[1] ? req1_op : req0_op;
  assign sel_a    = gnt[1] ? req1_a  : req0_a;
  assign sel_b    = gnt[1] ? req1_b  : req0_b;
  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; the ALU inputs always reflect the latched operands so they stay quiet
  // outside EXEC.
  always_comb begin
    req0_ready  = gnt[0];
    req1_ready  = gnt[1];
    rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    rsp1_valid  = (state_q == ST_RESP) && owner_q;
    rsp0_result = res_q;
    rsp0_zero   = zero_q;
    rsp0_err    = rerr_q;
    rsp1_result = res_q;
    rsp1_zero   = zero_q;
    rsp1_err    = rerr_q;
    alu_reg1    = a_q;
    alu_reg2    = b_q;
    alu_op      = op_q;
  end

  // Operand capture on the request handshake, response capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        a_q     <= sel_a;
        b_q     <= sel_b;
        owner_q <= gnt[1];
        err_q   <= (sel_op > LegalMax);
      end
      if (state_q == ST_EXEC) begin
        res_q  <= err_q ? '0 : alu_result;
        zero_q <= err_q ? 1'b1 : alu_zero;
        rerr_q <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: acts as the ALU, drives both requesters and scores
// every response against an expectation queued at request acceptance.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic          rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [W-1:0]  rsp0_result, rsp1_result;
  logic [W-1:0]  alu_reg1, alu_reg2, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_zero;

  typedef struct packed {
    logic         port;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  logic grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .WIDTH (W),
    .OPW   (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err),
    .alu_reg1    (alu_reg1),
    .alu_reg2    (alu_reg2),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Illegal opcodes return garbage so an arbiter that forwards it gets caught.
  function automatic logic [W-1:0] alu_model(input logic [OW-1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_SLL:  return a << b[4:0];
      ALU_SUB:  return a - b;
      ALU_SRL:  return a >> b[4:0];
      ALU_MUL:  return 32'(a * b);
      ALU_XOR:  return a ^ b;
      ALU_SLTU: return {31'b0, (a < b)};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic exp_t expect_rsp(input logic port, input logic [OW-1:0] op,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.port = port;
    if (op > 4'b1000) begin
      e.res  = '0;
      e.zero = 1'b1;
      e.err  = 1'b1;
    end else begin
      e.res  = alu_model(op, a, b);
      e.zero = (e.res == '0);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  always_comb begin
    alu_result = alu_model(alu_op, alu_reg1, alu_reg2);
    alu_zero   = (alu_result == '0);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_rsp(input logic port, input logic [W-1:0] res,
                             input logic zero, input logic err);
    exp_t e;
    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("sb_port", 32'(port), 32'(e.port));
      check_eq("sb_result", res, e.res);
      check_eq("sb_zero", 32'(zero), 32'(e.zero));
      check_eq("sb_err", 32'(err), 32'(e.err));
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check_eq("single_ready", 32'(req0_ready & req1_ready), 32'd0);
      check_eq("single_rsp", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(expect_rsp(1'b0, req0_op, req0_a, req0_b));
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(expect_rsp(1'b1, req1_op, req1_a, req1_b));
        grant_log.push_back(1'b1);
      end
      if (rsp0_valid && rsp0_ready) compare_rsp(1'b0, rsp0_result, rsp0_zero, rsp0_err);
      if (rsp1_valid && rsp1_ready) compare_rsp(1'b1, rsp1_result, rsp1_zero, rsp1_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input logic port);
    int cnt = 0;
    @(negedge clk);
    while (!(port ? rsp1_valid : rsp0_valid) && cnt < 20) begin
      step();
      @(negedge clk);
      cnt++;
    end
    check_eq("rsp_wait", 32'(cnt < 20), 32'd1);
    step();
  endtask

  task automatic do_op(input logic port, input logic [OW-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int cnt = 0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && cnt < 20) begin
      step();
      @(negedge clk);
      cnt++;
    end
    check_eq("accept_wait", 32'(cnt < 20), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(port);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("rst_rsp0_result", rsp0_result, 32'd0);
    check_eq("rst_rsp1_zero_err", 32'({rsp1_zero, rsp1_err}), 32'd0);
    check_eq("rst_alu_reg1", alu_reg1, 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    step();
    rst = 1'b0;

    // Single op: ADD 5+7 with 2-cycle latency
    step();
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_req0_ready_c0", 32'(req0_ready), 32'd1);
    check_eq("t1_req1_ready_c0", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_no_rsp_c1", 32'(rsp0_valid), 32'd0);
    check_eq("t1_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check_eq("t1_alu_reg1", alu_reg1, 32'd5);
    check_eq("t1_alu_reg2", alu_reg2, 32'd7);
    step();
    @(negedge clk);
    check_eq("t1_rsp0_valid_c2", 32'(rsp0_valid), 32'd1);
    check_eq("t1_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    check_eq("t1_result", rsp0_result, 32'd12);
    step();
    @(negedge clk);
    check_eq("t1_rsp0_drop_c3", 32'(rsp0_valid), 32'd0);

    // Contention after reset: grants must alternate starting with port 0
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    grant_log.delete();
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd9;    req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'hF0;   req1_b = 32'h0F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (12) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step();
    check_eq("t2_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
      check_eq("t2_grant_order", 32'(grant_log[i]), 32'(i % 2));
    end

    // Backpressure on port 1 while port 0 waits
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_op = ALU_SLL; req1_a = 32'd1; req1_b = 32'd4;
    @(negedge clk);
    check_eq("t3_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 32'h0000_FFFF; req0_b = 32'h0F0F_0F0F;
    @(negedge clk);
    check_eq("t3_no_accept_exec", 32'(req0_ready), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_valid", 32'(rsp1_valid), 32'd1);
      check_eq("t3_hold_result", rsp1_result, 32'd16);
      check_eq("t3_hold_zero", 32'(rsp1_zero), 32'd0);
      check_eq("t3_no_accept_resp", 32'(req0_ready), 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_no_accept_hs", 32'(req0_ready), 32'd0);
    step();
    rsp1_ready = 1'b0;
    @(negedge clk);
    check_eq("t3_accept_after", 32'(req0_ready), 32'd1);
    check_eq("t3_rsp1_cleared", 32'(rsp1_valid), 32'd0);
    step();
    req0_valid = 1'b0;
    wait_rsp(1'b0);

    // Illegal opcodes, including the first one past SLTU
    do_op(1'b0, 4'b1010, 32'd3, 32'd4);
    do_op(1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd0);
    do_op(1'b0, 4'b1111, 32'd1, 32'd1);

    // SLTU / MUL / shift edges
    do_op(1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
    do_op(1'b0, ALU_MUL, 32'h0001_0000, 32'h0001_0000);
    do_op(1'b1, ALU_SRL, 32'h8000_0000, 32'd31);
    do_op(1'b0, ALU_OR, 32'hA000_0000, 32'h0000_0005);

    // Mixed ops
    for (int i = 0; i < 10; i++) begin
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    // Reset during EXEC discards the op and re-prefers port 0
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    check_eq("t6_accept", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    check_eq("t6_rst_rsp0", 32'(rsp0_valid), 32'd0);
    check_eq("t6_rst_rsp1", 32'(rsp1_valid), 32'd0);
    check_eq("t6_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      step();
    end
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd10; req1_b = 32'd20;
    @(negedge clk);
    check_eq("t6_port0_first", 32'(req0_ready), 32'd1);
    check_eq("t6_port1_wait", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(1'b0);

    repeat (3) step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch helper.
- Uses valid/ready handshakes on both requests and responses, with round-robin arbitration.
- Captures operands into registers, drives the ALU for one cycle, then holds the result until the owning requester accepts it.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; must equal the ALU width.
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OPW  requester 0 ALU opcode.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_result  out  WIDTH  result value.
- rsp0_zero  out  1  result == 0.
- rsp0_err  out  1  opcode was illegal.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_err: same as port 0, for requester 1.
- alu_reg1  out  WIDTH  ALU operand A.
- alu_reg2  out  WIDTH  ALU operand B.
- alu_op  out  OPW  ALU opcode.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; last_grant=1, so port 0 wins the first tie; operand/opcode regs = 0; all rsp*_valid/result/zero/err = 0; req*_ready = 0.
- Legal opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB.
  - 0101 SRL, 0110 MUL (low WIDTH bits), 0111 XOR, 1000 SLTU (unsigned).
  - 1001–1111 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - reqN_ready=1 only for the granted port; ready depends on valid.
  - On the handshake: latch op/a/b, owner, and err = (op > 1000); set last_grant=owner; go to EXEC.
  - No valid: stay in IDLE, all ready=0.
- EXEC (exactly 1 cycle):
  - alu_reg1/alu_reg2/alu_op are driven from the latched regs.
  - At the end of the cycle, capture the response: if err, result=0, zero=1, err=1; otherwise result=alu_result, zero=alu_zero.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1; result/zero/err are held stable while valid and ready is low.
  - On rsp<owner>_ready=1: clear valid and go to IDLE.
  - The non-owner rsp port stays at valid=0.
- ALU outputs: outside EXEC they hold their last latched values. Zeros are not forced, so the ALU inputs do not toggle.
- Latency and throughput:
  - Accepted at edge N, rsp_valid is high in cycle N+2.
  - Best case is one op per 3 cycles; a new request is never accepted in RESP.
- Ready timing: a response accepted in the same cycle rsp_valid rises still costs one cycle back in IDLE.
- Starvation: with both ports continuously valid, grants alternate 0,1,0,1.
- Reset mid-operation: an in-flight op is discarded; no response is issued; arbitration restarts with port 0 preferred.
- Widths: no extension or truncation in the arbiter; it forwards ALU width unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU opcode localparams (ALU_AND..ALU_SLTU), ALU_OP_MAX=4'b1000;
  - FSM state encoding ST_IDLE/ST_EXEC/ST_RESP (2 bits).
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a last_grant register and update enable. Reused later by the memory-port arbiter.

Test Plan:
- Single op: req0 ADD a=5, b=7, rsp0_ready=1 -> req0_ready in cycle 0, rsp0_valid in cycle 2 with result=12, zero=0, err=0; rsp1_valid stays 0.
- Contention: both valid continuously; port 0 SUB 9,9; port 1 XOR 0xF0,0x0F -> grants 0,1,0,1; rsp0 result=0, zero=1; rsp1 result=0xFF.
- Backpressure: req1 SLL 1,4 with rsp1_ready low for 5 cycles -> result=16 held stable; req0 is not accepted until the rsp1 handshake plus one cycle.
- Illegal opcode: req0 op=1010 -> rsp0 result=0, zero=1, err=1; the ALU output is ignored.
- SLTU/MUL edge: SLTU 0xFFFFFFFF,1 gives 0 with zero=1; MUL 0x10000,0x10000 gives 0.
- Reset in EXEC: assert rst during EXEC -> next cycle all valid/ready are 0 and no response appears; after rst drops, both valid -> port 0 granted first.
